// File: rtl/crossbar_cfg_pkg.sv
// Shared types and address-map constants for the crossbar select-vector programmer.
package crossbar_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StSettle
  } cfg_state_e;

  localparam int unsigned LANE_W          = 8;
  localparam int unsigned FIELDS_PER_WORD = 4;
  // Control word sits at WORDS + CTRL_OFS, active words start at WORDS + ACTIVE_OFS
  localparam int unsigned CTRL_OFS        = 0;
  localparam int unsigned ACTIVE_OFS      = 1;

  function automatic int unsigned calc_words(input int unsigned n_out);
    return (n_out + FIELDS_PER_WORD - 1) / FIELDS_PER_WORD;
  endfunction

endpackage

// File: rtl/crossbar_cfg_commit_fsm.sv
// Commit sequencer: one COMMIT cycle then a SETTLE_CYC-long settle window.
// Optional sticky lock built only when CROSSBAR_CFG_LOCK_EN is defined.
module crossbar_cfg_commit_fsm
  import crossbar_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_commit_req,
  input  logic i_lock_req,
  output logic o_commit,
  output logic o_busy,
  output logic o_settling,
  output logic o_locked
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  cfg_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_settling;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_settling <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_commit_req) begin
            r_state    <= StCommit;
            r_busy     <= 1'b1;
            r_settling <= 1'b1;
          end
        end
        StCommit: begin
          r_state <= StSettle;
          r_cnt   <= CNT_W'(SETTLE_CYC - 1);
        end
        StSettle: begin
          if (r_cnt == '0) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_settling <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_commit   = (r_state == StCommit);
  assign o_busy     = r_busy;
  assign o_settling = r_settling;

`ifdef CROSSBAR_CFG_LOCK_EN
  logic r_lock;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock <= 1'b0;
    end else if (i_commit_req && i_lock_req) begin
      r_lock <= 1'b1;
    end
  end

  assign o_locked = r_lock;
`else
  logic w_unused_lock_req;
  assign w_unused_lock_req = i_lock_req;
  assign o_locked          = 1'b0;
`endif

endmodule

// File: rtl/crossbar_cfg_writer.sv
// Bus-programmable shadow/active crossbar select vector with atomic commit.
// Define CROSSBAR_CFG_LOCK_EN to build the sticky post-commit write lock.
module crossbar_cfg_writer
  import crossbar_cfg_pkg::*;
#(
  parameter  int unsigned N_OUT      = 24,
  parameter  int unsigned N_IN       = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned ADDR_W     = 4,
  parameter  int unsigned SETTLE_CYC = 4,
  localparam int unsigned SEL_W      = $clog2(N_IN),
  localparam int unsigned WORDS      = calc_words(N_OUT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   err_o,
  output logic [N_OUT*SEL_W-1:0] cfg_o,
  output logic                   settling_o,
  output logic                   busy_o
);

  localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'((1 << SEL_W) - 1);

  logic [N_OUT-1:0][SEL_W-1:0] r_shadow;
  logic [N_OUT-1:0][SEL_W-1:0] r_active;
  logic                        r_rvalid;
  logic                        r_err;
  logic [DATA_W-1:0]           r_rdata;

  logic [31:0]       w_addr;
  logic              w_is_shadow, w_is_ctrl, w_is_active;
  logic              w_lanes_bad, w_wr_err, w_rd_err;
  logic              w_gnt, w_wr_ok, w_commit_req, w_lock_req;
  logic              w_commit, w_busy, w_settling, w_locked;
  logic [DATA_W-1:0] w_rd_shadow, w_rd_active, w_status, w_rdata;

  assign w_addr      = 32'(addr_i);
  assign w_is_shadow = (w_addr < WORDS);
  assign w_is_ctrl   = (w_addr == WORDS + CTRL_OFS);
  assign w_is_active = (w_addr >= WORDS + ACTIVE_OFS) && (w_addr < 2 * WORDS + ACTIVE_OFS);

  // Only lanes that map to a real output are checked; padding lanes are don't-care
  always_comb begin
    logic [LANE_W-1:0] lane;
    w_lanes_bad = 1'b0;
    for (int k = 0; k < FIELDS_PER_WORD; k++) begin
      lane = wdata_i[k*LANE_W +: LANE_W];
      if (w_addr * FIELDS_PER_WORD + 32'(k) < N_OUT) begin
        if (((lane & ~LANE_MASK) != '0) || (32'(lane & LANE_MASK) >= N_IN)) begin
          w_lanes_bad = 1'b1;
        end
      end
    end
  end

  assign w_wr_err     = w_locked | ~(w_is_shadow | w_is_ctrl) | (w_is_shadow & w_lanes_bad);
  assign w_rd_err     = ~(w_is_shadow | w_is_ctrl | w_is_active);
  assign w_gnt        = req_i & ~(we_i & w_busy);
  assign w_wr_ok      = w_gnt & we_i & ~w_wr_err;
  assign w_commit_req = w_wr_ok & w_is_ctrl & wdata_i[0];
  assign w_lock_req   = wdata_i[1];

  // During COMMIT the active copy is about to become the shadow; reads see that value
  always_comb begin
    w_rd_shadow = '0;
    w_rd_active = '0;
    for (int o = 0; o < N_OUT; o++) begin
      if (w_addr == o / FIELDS_PER_WORD) begin
        w_rd_shadow[(o % FIELDS_PER_WORD) * LANE_W +: SEL_W] = r_shadow[o];
      end
      if (w_addr == WORDS + ACTIVE_OFS + o / FIELDS_PER_WORD) begin
        w_rd_active[(o % FIELDS_PER_WORD) * LANE_W +: SEL_W] =
            w_commit ? r_shadow[o] : r_active[o];
      end
    end
  end

  assign w_status = DATA_W'({w_locked, w_busy, 1'b0});
  assign w_rdata  = w_is_shadow ? w_rd_shadow : (w_is_ctrl ? w_status : w_rd_active);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & (we_i ? w_wr_err : w_rd_err);
      r_rdata  <= (w_gnt & ~we_i & ~w_rd_err) ? w_rdata : '0;
      for (int o = 0; o < N_OUT; o++) begin
        if (w_wr_ok && w_is_shadow && (w_addr == o / FIELDS_PER_WORD)) begin
          r_shadow[o] <= wdata_i[(o % FIELDS_PER_WORD) * LANE_W +: SEL_W];
        end
      end
      if (w_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  crossbar_cfg_commit_fsm #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_commit_fsm (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_commit_req (w_commit_req),
    .i_lock_req   (w_lock_req),
    .o_commit     (w_commit),
    .o_busy       (w_busy),
    .o_settling   (w_settling),
    .o_locked     (w_locked)
  );

  assign gnt_o      = w_gnt;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign err_o      = r_err;
  assign cfg_o      = r_active;
  assign settling_o = w_settling;
  assign busy_o     = w_busy;

endmodule

// File: tb/tb_crossbar_cfg_writer.sv
// Randomised bench for crossbar_cfg_writer against an array-based reference model.
module tb_crossbar_cfg_writer;

  localparam int N_OUT  = 24;
  localparam int N_IN   = 32;
  localparam int SEL_W  = 5;
  localparam int WORDS  = 6;
  localparam int CTRL   = 6;
  localparam int SETTLE = 4;
`ifdef CROSSBAR_CFG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req = 1'b0;
  logic                   we = 1'b0;
  logic [3:0]             addr = '0;
  logic [31:0]            wdata = '0;
  logic                   gnt, rvalid, err, settling, busy;
  logic [31:0]            rdata;
  logic [N_OUT*SEL_W-1:0] cfg;

  crossbar_cfg_writer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err),
    .cfg_o      (cfg),
    .settling_o (settling),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain arrays, a lock bit and the cycle in which the last commit was granted
  int m_shadow[N_OUT];
  int m_active[N_OUT];
  bit m_lock;
  int m_cg = -1000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return (c >= m_cg + 1) && (c <= m_cg + 1 + SETTLE);
  endfunction

  function automatic logic [N_OUT*SEL_W-1:0] m_cfg();
    logic [N_OUT*SEL_W-1:0] v;
    v = '0;
    for (int o = 0; o < N_OUT; o++) v[o*SEL_W +: SEL_W] = SEL_W'(m_active[o]);
    return v;
  endfunction

  function automatic logic [31:0] m_word(input bit act, input int w);
    logic [31:0] r;
    int          o;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      o = 4 * w + k;
      if (o < N_OUT) r[8*k +: 8] = 8'(act ? m_active[o] : m_shadow[o]);
    end
    return r;
  endfunction

  function automatic bit m_legal(input int w, input logic [31:0] d);
    logic [7:0] v;
    for (int k = 0; k < 4; k++) begin
      v = d[8*k +: 8];
      if (4 * w + k < N_OUT) begin
        if ((v >> SEL_W) != 0 || int'(v) % (1 << SEL_W) >= N_IN) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic m_clear();
    for (int o = 0; o < N_OUT; o++) begin
      m_shadow[o] = 0;
      m_active[o] = 0;
    end
    m_lock = 1'b0;
    m_cg   = -1000;
  endtask

  // Entered and left at posedge+1; issues one request and checks it against the model
  task automatic txn(input bit w, input int a, input logic [31:0] d);
    int          issue, gc, exp_gc;
    logic        exp_err;
    logic [31:0] exp_rd;
    issue = cyc;
    if (!m_busy(issue)) check_eq("cfg_idle", cfg, m_cfg());
    check_eq("busy", busy, m_busy(issue));
    check_eq("settling", settling, m_busy(issue));
    exp_gc = (w && m_busy(issue)) ? m_cg + SETTLE + 2 : issue;
    req = 1'b1; we = w; addr = a[3:0]; wdata = d;
    #1;
    while (!gnt && cyc - issue < 50) begin
      @(posedge clk); #2;
    end
    gc = cyc;
    check_eq($sformatf("grant_wait we=%0d a=%0d", w, a), gc - issue, exp_gc - issue);
    exp_err = 1'b0;
    exp_rd  = '0;
    if (!w) begin
      if (a < WORDS) exp_rd = m_word(1'b0, a);
      else if (a == CTRL) exp_rd = {29'b0, LOCK_EN & m_lock, m_busy(gc), 1'b0};
      else if (a <= 2 * WORDS) exp_rd = m_word(1'b1, a - WORDS - 1);
      else exp_err = 1'b1;
    end else begin
      if (LOCK_EN && m_lock) exp_err = 1'b1;
      else if (a < WORDS) begin
        if (!m_legal(a, d)) exp_err = 1'b1;
        else for (int k = 0; k < 4; k++) if (4 * a + k < N_OUT) m_shadow[4*a+k] = int'(d[8*k +: SEL_W]);
      end else if (a == CTRL) begin
        if (d[0]) begin
          m_cg     = gc;
          m_active = m_shadow;
          if (LOCK_EN && d[1]) m_lock = 1'b1;
        end
      end else exp_err = 1'b1;
    end
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("rvalid", rvalid, 1'b1);
    check_eq($sformatf("err we=%0d a=%0d", w, a), err, exp_err);
    if (!w && !exp_err) check_eq($sformatf("rdata a=%0d", a), rdata, exp_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_shadow_data();
    logic [31:0] d;
    for (int k = 0; k < 4; k++)
      d[8*k +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255))
                                                : 8'($urandom_range(0, 31));
    return d;
  endfunction

  initial begin
    logic [N_OUT*SEL_W-1:0] old_cfg;
    int                     n, a, r, t0;
    logic [31:0]            d;
    m_clear();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cfg", cfg, '0);
    check_eq("rst_settling", settling, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_rdata", rdata, '0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i <= 2 * WORDS; i++) txn(1'b0, i, '0);

    // Programming, read-back and commit latency
    txn(1'b1, 0, 32'h1F03_0007);
    txn(1'b0, 0, '0);
    check_eq("cfg_before_commit", cfg, '0);
    old_cfg = m_cfg();
    txn(1'b1, CTRL, 32'h1);
    check_eq("cfg_in_commit", cfg, old_cfg);
    n = 0;
    while (settling && n < 20) begin
      n++;
      @(posedge clk); #1;
      if (n == 1) check_eq("cfg_latency", cfg, m_cfg());
    end
    check_eq("settle_len", n, SETTLE + 1);
    check_eq("sel_out0", cfg[0*SEL_W +: SEL_W], 5'd7);
    check_eq("sel_out2", cfg[2*SEL_W +: SEL_W], 5'd3);
    check_eq("sel_out3", cfg[3*SEL_W +: SEL_W], 5'd31);

    // Illegal writes and addresses
    txn(1'b1, 1, 32'h0000_2000);
    txn(1'b0, 1, '0);
    txn(1'b1, 7, 32'h0);
    txn(1'b1, 15, 32'h0);
    txn(1'b0, 15, '0);
    txn(1'b1, CTRL, 32'h0);

    // Reads during the sequence are not stalled; writes wait until idle
    txn(1'b1, 1, 32'h0102_0304);
    txn(1'b1, CTRL, 32'h1);
    txn(1'b0, 8, '0);
    txn(1'b0, CTRL, '0);
    txn(1'b1, 2, 32'h0A0B_0C0D);
    txn(1'b1, CTRL, 32'h1);

    // Asynchronous reset in the middle of SETTLE
    idle(2);
    #2;
    t0 = cyc;
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_settling", settling, 1'b0);
    check_eq("arst_cfg", cfg, '0);
    check_eq("arst_no_edge", cyc, t0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    txn(1'b0, 0, '0);
    txn(1'b0, 7, '0);

    // Randomised traffic (lock bit kept clear so the run stays writable)
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 10) txn(1'b1, CTRL, $urandom & ~32'h2);
      else if (r < 45) txn(1'b1, $urandom_range(0, WORDS - 1), rand_shadow_data());
      else if (r < 55) begin
        a = $urandom_range(0, 15);
        d = $urandom;
        if (a == CTRL) d[1] = 1'b0;
        txn(1'b1, a, d);
      end else txn(1'b0, $urandom_range(0, 15), '0);
    end
    idle(SETTLE + 2);

    // Lock request together with a commit
    txn(1'b1, 0, 32'h0102_0304);
    txn(1'b1, CTRL, 32'h3);
    idle(SETTLE + 2);
    txn(1'b0, CTRL, '0);
    txn(1'b1, 1, 32'h0506_0708);
    txn(1'b0, 1, '0);
    txn(1'b1, CTRL, 32'h1);
    idle(SETTLE + 2);
    txn(1'b0, 7, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/crossbar_cfg_writer.md
Name: crossbar_cfg_writer

Overview:
- Bus-side programmer that produces the per-output select vector consumed by the crossbar's config input.
- Holds a shadow copy of the select vector (bus-writable) and an active copy (driven to the crossbar).
- Shadow is transferred to active atomically on a commit command, followed by a settle window that tells PMU counters to ignore the switch-over.
- Sits between the SoC register bus and the crossbar/PMU.

Parameters:
- N_OUT, 24, number of crossbar outputs (PMU events).
- N_IN, 32, number of crossbar inputs (SoC events).
- SEL_W, $clog2(N_IN), width of one select field (localparam).
- DATA_W, 32, bus data width; each select field occupies one 8-bit lane, so 4 fields per word.
- WORDS, ceil(N_OUT/4), number of config words (localparam; 6 by default).
- ADDR_W, 4, word address width; must satisfy 2^ADDR_W >= 2*WORDS+1.
- SETTLE_CYC, 4, settle window length in cycles (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_W  word address.
- wdata_i  in  DATA_W  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, 1 cycle after grant.
- rdata_o  out  DATA_W  read data, valid with rvalid_o.
- err_o  out  1  error response, valid with rvalid_o.
- cfg_o  out  N_OUT*SEL_W  active selects, flattened; output k uses bits [k*SEL_W +: SEL_W].
- settling_o  out  1  high during commit and settle window.
- busy_o  out  1  commit FSM not IDLE.

Behaviour:
- Reset values: all shadow and active fields 0; all outputs 0; FSM in IDLE.
- Address map:
  - 0..WORDS-1: shadow words, read/write.
  - WORDS: control/status. Write bit0=1 requests commit. Read returns {.., bit2 lock, bit1 busy, bit0 0}.
  - WORDS+1..2*WORDS: active words, read-only.
  - Any other address: error.
- Field packing: field k of word w is select for output 4w+k, in lane bits [8k +: SEL_W].
  - Reads return 0 in lane bits above SEL_W and in lanes for outputs >= N_OUT.
- Write legality: a write to a shadow word is rejected (err_o=1, no state change) if, in any lane with output < N_OUT:
  - the select value is >= N_IN, or
  - any lane bit above SEL_W is nonzero.
  - Nonzero data in lanes for outputs >= N_OUT is ignored.
- Writes to the active-word range are errors.
- Handshake:
  - gnt_o = req_i, except writes are stalled (gnt_o=0) while busy_o=1.
  - Reads are never stalled.
  - Requester holds req/we/addr/wdata until granted.
  - rvalid_o pulses exactly 1 cycle after each grant, with rdata_o/err_o. No pipelining beyond 1 outstanding.
- FSM states: IDLE, COMMIT, SETTLE.
  - IDLE -> COMMIT on a granted write to WORDS with bit0=1.
  - COMMIT, 1 cycle: active <= shadow, all fields updated on the same edge; settling_o=1.
  - COMMIT -> SETTLE; load counter with SETTLE_CYC-1.
  - SETTLE: decrement each cycle; settling_o=1; at 0 -> IDLE.
  - busy_o=1 in COMMIT and SETTLE.
- Latency: cfg_o changes on the edge ending the COMMIT cycle, i.e. 2 edges after the commit write is granted.
  - settling_o is high for 1+SETTLE_CYC cycles total.
- Boundary conditions:
  - Commit with shadow equal to active still runs the full sequence.
  - A write to WORDS with bit0=0 completes with no error and no commit.
  - A read of active words during COMMIT/SETTLE returns the post-edge value.
  - Reset mid-SETTLE returns to IDLE and clears active, shadow and lock immediately (asynchronous).

Optional Feature:
- Macro: CROSSBAR_CFG_LOCK_EN.
- Enabled:
  - Control-word bit1 written as 1 together with a commit sets a sticky lock, set as the commit is accepted.
  - Once locked, every subsequent write errors with no state change; reads stay legal.
  - Lock clears only on rst_i. Status bit2 reflects lock.
- Disabled: bit1 is ignored and status bit2 reads 0.

Decomposition:
- Package crossbar_cfg_pkg:
  - FSM state enum.
  - Lane width constant (8) and fields-per-word constant (4).
  - Address-decode constants: CTRL offset, ACTIVE base.
  - Function computing WORDS from N_OUT.
- Natural sub-module: crossbar_cfg_commit_fsm, containing state, settle counter, busy/settling and lock.

Test Plan:
- Reset, then read all 13 addresses -> every rdata_o = 0, err_o = 0, cfg_o = 0, settling_o = 0.
- Write word 0 = 0x1F_03_00_07, read it back -> rdata 0x1F030007. cfg_o unchanged until commit.
  - Then write CTRL=1 -> output 0 select =7, output 2 select =3, output 3 select =31, 2 edges after grant.
  - settling_o high for exactly 5 cycles.
- Write word 1 = 0x00_00_20_00 (select 32) -> err_o=1 and shadow word 1 still 0.
  - Write to address 7 (active range) -> err_o=1.
  - Address 15 -> err_o=1.
- Commit, then hold a shadow write during SETTLE -> gnt_o=0 until IDLE, then granted.
  - A read issued during SETTLE is granted the same cycle.
- Assert rst_i during SETTLE -> busy_o, settling_o and cfg_o drop to 0 without a clock edge.
- With CROSSBAR_CFG_LOCK_EN: write CTRL=0x3 -> commit proceeds and status reads 0x4 after settle.
  - Any later shadow write -> err_o=1 and shadow unchanged.
